// File: rtl/ysyx_25040101_lsu.sv
// ============================================================================
// Module   : ysyx_25040101_lsu
// Brief    : Multi-cycle load/store unit with a single-outstanding
//            valid/ready memory port and byte-lane load extension.
//            Optional misaligned-access trap: YSYX_25040101_LSU_MISALIGN_CHECK_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040101_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_wen_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_wen_q,   mem_wen_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [1:0]        lane_q,      lane_d;
    logic [1:0]        size_q,      size_d;
    logic              unsigned_q,  unsigned_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic              err_q,       err_d;

    logic              accept;
    logic              misalign;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_ext;

    assign accept = (state_q == S_IDLE) && req_valid_i;

`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (req_size_i)
            2'b01:   misalign = req_addr_i[0];
            2'b10,
            2'b11:   misalign = |req_addr_i[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = misalign ? S_RESP : S_REQ;
            S_REQ:   if (mem_ready_i) state_d = S_WAIT;
            S_WAIT:  if (mem_rvalid_i) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane select and extension of the returned word
    always_comb begin
        byte_v   = mem_rdata_i[{lane_q, 3'b000} +: 8];
        half_v   = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata_i;
        case (size_q)
            2'b00:   load_ext = {{24{~unsigned_q & byte_v[7]}}, byte_v};
            2'b01:   load_ext = {{16{~unsigned_q & half_v[15]}}, half_v};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        lane_d      = lane_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (accept && !misalign) begin
            mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
            mem_wen_d   = req_wen_i;
            lane_d      = req_addr_i[1:0];
            size_d      = req_size_i;
            unsigned_d  = req_unsigned_i;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
            if (req_wen_i) begin
                case (req_size_i)
                    2'b00: begin
                        mem_wmask_d = 4'b0001 << req_addr_i[1:0];
                        mem_wdata_d = {4{req_wdata_i[7:0]}};
                    end
                    2'b01: begin
                        mem_wmask_d = 4'b0011 << {req_addr_i[1], 1'b0};
                        mem_wdata_d = {2{req_wdata_i[15:0]}};
                    end
                    default: begin
                        mem_wmask_d = 4'b1111;
                        mem_wdata_d = req_wdata_i;
                    end
                endcase
            end
        end
        if (accept && misalign) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
        if ((state_q == S_WAIT) && mem_rvalid_i) begin
            rdata_d = mem_wen_q ? 32'd0 : load_ext;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        req_ready_o  = (state_q == S_IDLE);
        mem_valid_o  = (state_q == S_REQ);
        resp_valid_o = (state_q == S_RESP);
        mem_addr_o   = mem_addr_q;
        mem_wen_o    = mem_wen_q;
        mem_wdata_o  = mem_wdata_q;
        mem_wmask_o  = mem_wmask_q;
        resp_rdata_o = rdata_q;
`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
        resp_err_o   = err_q;
`else
        resp_err_o   = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040101_lsu.sv
// ============================================================================
// Module   : tb_ysyx_25040101_lsu
// Brief    : Scoreboard bench for ysyx_25040101_lsu with directed and random
//            accesses and a responding memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040101_lsu;

`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_wen_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    ysyx_25040101_lsu #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_wen_i      (req_wen_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wen_o      (mem_wen_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_wmask_o    (mem_wmask_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic model_misaligned(logic [31:0] a, logic [1:0] s);
        int off;
        off = a % 4;
        return MISALIGN_EN && (((s == 2'd1) && (off % 2 != 0)) || ((s >= 2'd2) && (off != 0)));
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] s, logic uns,
                                               logic [31:0] word);
        logic [31:0] v;
        int          off;
        off = a % 4;
        if (s == 2'd0) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (s == 2'd1) begin
            v = (word >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_mask(logic [31:0] a, logic [1:0] s);
        int off;
        off = a % 4;
        if (s == 2'd0) return 4'(1 << off);
        if (s == 2'd1) return 4'(3 << ((off >= 2) ? 2 : 0));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] w, logic [1:0] s);
        if (s == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // Response monitor: every completion must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_resp actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata_o, e.rdata);
                chk("resp_err", {31'd0, resp_err_o}, {31'd0, e.err});
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (!req_ready_o && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    endtask

    task automatic do_access(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata, input logic [31:0] word,
                             input int rd, input int rv);
        exp_t        e;
        logic        mis;
        logic [31:0] held_addr;
        wait_idle();
        mis     = model_misaligned(addr, size);
        e.rdata = (mis || wen) ? 32'd0 : model_load(addr, size, uns, word);
        e.err   = mis;
        e.cyc   = mis ? 32'(cyc + 1) : 32'(cyc + 3 + rd + rv);
        sb.push_back(e);
        req_valid_i    = 1'b1;
        req_addr_i     = addr;
        req_wen_i      = wen;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        @(negedge clk);
        // Garbage on the core side must be ignored while busy
        req_addr_i  = $urandom;
        req_wen_i   = 1'($urandom);
        req_size_i  = 2'($urandom);
        req_wdata_i = $urandom;
        if (mis) begin
            req_valid_i = 1'b0;
            chk("mis_no_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        end else begin
            chk("mem_valid", {31'd0, mem_valid_o}, 32'd1);
            chk("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
            chk("mem_wen", {31'd0, mem_wen_o}, {31'd0, wen});
            chk("mem_wmask", {28'd0, mem_wmask_o}, wen ? {28'd0, model_mask(addr, size)} : 32'd0);
            if (wen) chk("mem_wdata", mem_wdata_o, model_wdata(wdata, size));
            held_addr = mem_addr_o;
            for (int i = 0; i < rd; i++) begin
                mem_ready_i  = 1'b0;
                mem_rvalid_i = 1'($urandom);
                mem_rdata_i  = $urandom;
                @(negedge clk);
                chk("stall_valid", {31'd0, mem_valid_o}, 32'd1);
                chk("stall_addr", mem_addr_o, held_addr);
                chk("stall_ready", {31'd0, req_ready_o}, 32'd0);
            end
            mem_ready_i  = 1'b1;
            mem_rvalid_i = 1'($urandom);
            mem_rdata_i  = $urandom;
            @(negedge clk);
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            chk("valid_dropped", {31'd0, mem_valid_o}, 32'd0);
            for (int i = 0; i < rv; i++) begin
                mem_ready_i = 1'($urandom);
                @(negedge clk);
                chk("wait_ready", {31'd0, req_ready_o}, 32'd0);
            end
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = word;
            req_valid_i  = 1'b0;
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        @(negedge clk);
        chk("rdata_hold", resp_rdata_o, e.rdata);
    endtask

    task automatic reset_in_wait();
        wait_idle();
        req_valid_i    = 1'b1;
        req_addr_i     = 32'h8000_0010;
        req_wen_i      = 1'b0;
        req_size_i     = 2'd2;
        req_unsigned_i = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        chk("stale_no_resp", {31'd0, resp_valid_o}, 32'd0);
        chk("stale_ready", {31'd0, req_ready_o}, 32'd1);
        chk("stale_rdata", resp_rdata_o, 32'd0);
    endtask

    initial begin
        int guard;
        rst            = 1'b1;
        req_valid_i    = 1'b0;
        req_addr_i     = '0;
        req_wen_i      = 1'b0;
        req_size_i     = '0;
        req_unsigned_i = 1'b0;
        req_wdata_i    = '0;
        mem_ready_i    = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("reset_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("reset_rdata", resp_rdata_o, 32'd0);
        chk("reset_err", {31'd0, resp_err_o}, 32'd0);
        chk("reset_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("reset_mem_addr", mem_addr_o, 32'd0);
        chk("reset_mem_wmask", {28'd0, mem_wmask_o}, 32'd0);
        chk("reset_mem_wdata", mem_wdata_o, 32'd0);
        chk("reset_mem_wen", {31'd0, mem_wen_o}, 32'd0);

        do_access(32'h8000_0004, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, 0);
        do_access(32'h8000_0004, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0);
        do_access(32'h8000_0003, 1'b1, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 0, 0);
        do_access(32'h8000_0002, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80F1_7F01, 0, 0);
        do_access(32'h8000_0002, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80F1_7F01, 0, 0);
        do_access(32'h8000_0002, 1'b0, 2'd1, 1'b0, 32'h0, 32'h80F1_7F01, 0, 0);
        do_access(32'h8000_0008, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 5, 3);
        do_access(32'h8000_0002, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 0);
        do_access(32'h8000_0001, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 1, 1);
        reset_in_wait();

        for (int n = 0; n < 80; n++) begin
            do_access($urandom, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
